// File: rtl/weight_pingpong_buffer.sv
// weight_pingpong_buffer: double-banked weight store feeding a PE array.
// The shadow bank loads over a valid/ready bus while the active bank drives weight_out.
`default_nettype none

module weight_pingpong_buffer #(
  parameter int ROW_NUM = 32,
  parameter int COL_NUM = 32,
  parameter int DATA_W  = 8,
  parameter int BUS_W   = 32,
  parameter int KSIZE   = 3,
  localparam int WPR    = COL_NUM * DATA_W / BUS_W,
  localparam int RW     = $clog2(ROW_NUM) + 1,
  localparam int CW     = $clog2(WPR) + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                DW_PW_sel,
  input  logic [RW-1:0]                       row_en,
  input  logic [CW-1:0]                       col_words,
  input  logic                                valid_w,
  output logic                                ready_w,
  input  logic [BUS_W-1:0]                    weight_in,
  input  logic                                swap,
  output logic                                load_done,
  output logic                                shadow_full,
  output logic                                active_bank,
  output logic [ROW_NUM*COL_NUM*DATA_W-1:0]   weight_out
);

  localparam int BPW = BUS_W / DATA_W;
  localparam int G   = ROW_NUM / KSIZE;
  localparam int RI  = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int CI  = (WPR > 1) ? $clog2(WPR) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t           state;
  logic [BUS_W-1:0] mem [2][ROW_NUM][WPR];
  logic [1:0]       bank_pw;
  logic             mode_pw;
  logic [RW-1:0]    rows_q;
  logic [RW-1:0]    row_cnt;
  logic [CW-1:0]    cols_q;
  logic [CW-1:0]    col_cnt;
  logic             shadow;
  logic             last_row;
  logic             last_col;
  logic             start_ok;

  assign shadow   = ~active_bank;
  assign last_row = (row_cnt + RW'(1)) == rows_q;
  // DW rows are one word each, so every word closes its row
  assign last_col = !mode_pw || ((col_cnt + CW'(1)) == cols_q);
  assign start_ok = start && (row_en != '0) && (!DW_PW_sel || (col_words != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      active_bank <= 1'b0;
      bank_pw     <= 2'b00;
      mode_pw     <= 1'b0;
      rows_q      <= '0;
      cols_q      <= '0;
      row_cnt     <= '0;
      col_cnt     <= '0;
      ready_w     <= 1'b0;
      load_done   <= 1'b0;
      shadow_full <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROW_NUM; r++)
          for (int w = 0; w < WPR; w++)
            mem[b][r][w] <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            mode_pw <= DW_PW_sel;
            rows_q  <= (row_en > RW'(ROW_NUM)) ? RW'(ROW_NUM) : row_en;
            cols_q  <= (col_words > CW'(WPR)) ? CW'(WPR) : col_words;
            row_cnt <= '0;
            col_cnt <= '0;
            for (int r = 0; r < ROW_NUM; r++)
              for (int w = 0; w < WPR; w++)
                mem[shadow][r][w] <= '0;
            ready_w <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (valid_w && ready_w) begin
            mem[shadow][row_cnt[RI-1:0]][col_cnt[CI-1:0]] <= weight_in;
            if (last_row && last_col) begin
              ready_w     <= 1'b0;
              shadow_full <= 1'b1;
              load_done   <= 1'b1;
              state       <= S_FULL;
            end else if (last_col) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + RW'(1);
            end else begin
              col_cnt <= col_cnt + CW'(1);
            end
          end
        end
        S_FULL: begin
          if (swap) begin
            bank_pw[shadow] <= mode_pw;
            active_bank     <= ~active_bank;
            shadow_full     <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROW_NUM; r++) begin : g_row
    for (genvar c = 0; c < COL_NUM; c++) begin : g_col
      localparam int  GI    = r / KSIZE;
      localparam int  K     = r % KSIZE;
      localparam bit  IN_DW = (GI < G) && (c >= KSIZE * GI) && (c < KSIZE * GI + KSIZE);
      logic [DATA_W-1:0] pw_byte;
      logic [DATA_W-1:0] dw_byte;

      assign pw_byte = mem[active_bank][r][c / BPW][(c % BPW) * DATA_W +: DATA_W];

      // Diagonal KSIZE x KSIZE blocks: column c of the block reads row word c
      if (IN_DW) begin : g_dw
        assign dw_byte = mem[active_bank][c][0][(KSIZE - 1 - K) * DATA_W +: DATA_W];
      end else begin : g_zero
        assign dw_byte = '0;
      end

      assign weight_out[(r * COL_NUM + c) * DATA_W +: DATA_W] =
        bank_pw[active_bank] ? pw_byte : dw_byte;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_weight_pingpong_buffer.sv
// tb_weight_pingpong_buffer: directed self-checking bench for weight_pingpong_buffer.
`default_nettype none

module tb_weight_pingpong_buffer;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          DW_PW_sel;
  logic [5:0]    row_en;
  logic [3:0]    col_words;
  logic          valid_w;
  logic          ready_w;
  logic [31:0]   weight_in;
  logic          swap;
  logic          load_done;
  logic          shadow_full;
  logic          active_bank;
  logic [8191:0] weight_out;

  int checks = 0;
  int errors = 0;
  int ld_cnt;
  logic [31:0] sw [4];

  weight_pingpong_buffer dut (
    .clk(clk), .reset(reset), .start(start), .DW_PW_sel(DW_PW_sel),
    .row_en(row_en), .col_words(col_words), .valid_w(valid_w), .ready_w(ready_w),
    .weight_in(weight_in), .swap(swap), .load_done(load_done),
    .shadow_full(shadow_full), .active_bank(active_bank), .weight_out(weight_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pe(input int r, input int c);
    return weight_out[(r * 32 + c) * 8 +: 8];
  endfunction

  task automatic do_start(input logic pw, input logic [5:0] rows, input logic [3:0] cols);
    start = 1'b1; DW_PW_sel = pw; row_en = rows; col_words = cols;
    tick();
    start = 1'b0;
  endtask

  // Streams n back-to-back words base+i*step and counts load_done pulses seen.
  task automatic send_words(input int n, input logic [31:0] base, input logic [31:0] step);
    ld_cnt = 0;
    valid_w = 1'b1;
    for (int i = 0; i < n; i++) begin
      weight_in = base + i * step;
      tick();
      if (load_done) ld_cnt++;
    end
    valid_w = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; DW_PW_sel = 1'b0; row_en = '0; col_words = '0;
    valid_w = 1'b0; weight_in = '0; swap = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_ready", ready_w, 0);
    check("rst_full", shadow_full, 0);
    check("rst_bank", active_bank, 0);
    check("rst_done", load_done, 0);
    check("rst_wout", |weight_out, 0);

    // Pointwise load of two full rows
    do_start(1'b1, 6'd2, 4'd8);
    check("pw_ready", ready_w, 1);
    send_words(16, 32'h03020100, 32'h04040404);
    check("pw_done_hi", load_done, 1);
    check("pw_full", shadow_full, 1);
    check("pw_ready_lo", ready_w, 0);
    tick();
    if (load_done) ld_cnt++;
    check("pw_done_pulses", ld_cnt, 1);
    check("pw_preswap_wout", |weight_out, 0);
    do_swap();
    check("pw_bank", active_bank, 1);
    check("pw_full_clr", shadow_full, 0);
    check("pw_pe00", pe(0, 0), 8'h00);
    check("pw_pe0_31", pe(0, 31), 8'h1F);
    check("pw_pe10", pe(1, 0), 8'h20);
    check("pw_pe1_31", pe(1, 31), 8'h3F);

    // Swap while idle is ignored
    do_swap();
    check("idle_swap_bank", active_bank, 1);

    // Depthwise load into bank 0 while bank 1 stays visible
    do_start(1'b0, 6'd3, 4'd0);
    check("dw_ready", ready_w, 1);
    sw[0] = 32'h00A1B2C3; sw[1] = 32'h00D4E5F6; sw[2] = 32'h00112233;
    ld_cnt = 0;
    valid_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      weight_in = sw[i];
      tick();
      if (load_done) ld_cnt++;
      check("dw_hold_pe01", pe(0, 1), 8'h01);
    end
    valid_w = 1'b0;
    check("dw_done_pulses", ld_cnt, 1);
    check("dw_full", shadow_full, 1);
    do_start(1'b1, 6'd1, 4'd1);
    check("full_start_ign_full", shadow_full, 1);
    check("full_start_ign_ready", ready_w, 0);
    check("full_start_hold", pe(0, 31), 8'h1F);
    do_swap();
    check("dw_bank", active_bank, 0);
    check("dw_pe00", pe(0, 0), 8'hA1);
    check("dw_pe01", pe(0, 1), 8'hD4);
    check("dw_pe10", pe(1, 0), 8'hB2);
    check("dw_pe11", pe(1, 1), 8'hE5);
    check("dw_pe22", pe(2, 2), 8'h33);
    check("dw_pe30", pe(3, 0), 8'h00);
    check("dw_pe33", pe(3, 3), 8'h00);
    check("dw_pe03", pe(0, 3), 8'h00);

    // Stalled pointwise load: valid on every other cycle
    sw[0] = 32'hDDCCBBAA; sw[1] = 32'h44332211; sw[2] = 32'h88776655; sw[3] = 32'h78563412;
    do_start(1'b1, 6'd1, 4'd4);
    ld_cnt = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      valid_w = (cyc % 2 == 0);
      weight_in = valid_w ? sw[cyc / 2] : 32'hFFFFFFFF;
      tick();
      if (load_done) ld_cnt++;
      if (cyc == 6) check("stall_done_at4", load_done, 1);
    end
    valid_w = 1'b1; weight_in = 32'hEEEEEEEE;
    tick();
    valid_w = 1'b0;
    check("stall_done_pulses", ld_cnt, 1);
    do_swap();
    check("stall_bank", active_bank, 1);
    check("stall_pe00", pe(0, 0), 8'hAA);
    check("stall_pe03", pe(0, 3), 8'hDD);
    check("stall_pe04", pe(0, 4), 8'h11);
    check("stall_pe0_15", pe(0, 15), 8'h78);
    check("stall_pe0_16", pe(0, 16), 8'h00);
    check("stall_pe10", pe(1, 0), 8'h00);

    // Reset in the middle of a load
    do_start(1'b1, 6'd2, 4'd8);
    send_words(5, 32'h03020100, 32'h04040404);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ready", ready_w, 0);
    check("midrst_full", shadow_full, 0);
    check("midrst_bank", active_bank, 0);
    check("midrst_wout", |weight_out, 0);
    do_start(1'b1, 6'd2, 4'd8);
    send_words(16, 32'h03020100, 32'h04040404);
    tick();
    if (load_done) ld_cnt++;
    check("midrst_pulses", ld_cnt, 1);
    do_swap();
    check("midrst_pe0_31", pe(0, 31), 8'h1F);
    check("midrst_pe10", pe(1, 0), 8'h20);

    // Boundary: zero rows ignored, oversize rows clamp to 32
    do_start(1'b1, 6'd0, 4'd8);
    check("zero_rows_ready", ready_w, 0);
    do_start(1'b1, 6'd40, 4'd1);
    check("clamp_ready", ready_w, 1);
    send_words(31, 32'h0, 32'h1);
    check("clamp_31_done", ld_cnt, 0);
    check("clamp_31_full", shadow_full, 0);
    send_words(1, 32'd31, 32'h1);
    check("clamp_32_done", ld_cnt, 1);
    check("clamp_32_full", shadow_full, 1);
    do_swap();
    check("clamp_pe31_0", pe(31, 0), 8'd31);
    check("clamp_pe5_0", pe(5, 0), 8'd5);
    check("clamp_pe31_4", pe(31, 4), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/weight_pingpong_buffer.md
WEIGHT_PINGPONG_BUFFER -- requirements
Module: weight_pingpong_buffer

Interface
REQ-001 SHALL have parameter ROW_NUM, default 32, meaning PE array rows.
REQ-002 SHALL have parameter COL_NUM, default 32, meaning PE array columns.
REQ-003 SHALL have parameter DATA_W, default 8, meaning bits per weight.
REQ-004 SHALL have parameter BUS_W, default 32, meaning input bus width; COL_NUM*DATA_W divisible by BUS_W; WPR = COL_NUM*DATA_W/BUS_W (default 8).
REQ-005 SHALL have parameter KSIZE, default 3, meaning depthwise kernel width; G = ROW_NUM/KSIZE (integer division) DW groups.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-008 SHALL have port start, input, 1, requests a load into the shadow bank.
REQ-009 SHALL have port DW_PW_sel, input, 1, PW=1, DW=0, sampled on accepted start.
REQ-010 SHALL have port row_en, input, $clog2(ROW_NUM)+1, rows to load, sampled on accepted start.
REQ-011 SHALL have port col_words, input, $clog2(WPR)+1, bus words per row in PW, sampled on accepted start.
REQ-012 SHALL have ports valid_w (input, 1), ready_w (output, 1) and weight_in (input, BUS_W), the load handshake.
REQ-013 SHALL have port swap, input, 1, consumer request to make the shadow bank active.
REQ-014 SHALL have port load_done, output, 1, one-cycle pulse when the last word is written.
REQ-015 SHALL have port shadow_full, output, 1, high while a completed load awaits swap.
REQ-016 SHALL have port active_bank, output, 1, index of the bank driving weight_out.
REQ-017 SHALL have port weight_out, output, ROW_NUM*COL_NUM*DATA_W; PE(r,c) at bits [(r*COL_NUM+c)*DATA_W +: DATA_W].

Function
REQ-018 SHALL hold two banks, each ROW_NUM x WPR words of BUS_W bits; shadow bank = !active_bank.
REQ-019 SHALL implement FSM IDLE, LOAD, FULL; ready_w = 1 only in LOAD; shadow_full = 1 only in FULL.
REQ-020 IDLE: start with row_en!=0 and (DW or col_words!=0) SHALL latch mode/sizes, zero shadow bank, clear counters, go to LOAD; otherwise start is ignored.
REQ-021 SHALL clamp latched row_en to ROW_NUM and latched col_words to WPR.
REQ-022 LOAD: a word is accepted only in a cycle with valid_w & ready_w, written to shadow[row_cnt][col_cnt]; valid_w low stalls without losing counter state.
REQ-023 PW: col_cnt SHALL count 0..col_words-1 then wrap to 0 and increment row_cnt; DW: col_cnt stays 0 and row_cnt increments per word.
REQ-024 On the word with row_cnt = row_en-1 (and, in PW, col_cnt = col_words-1), SHALL pulse load_done next cycle and enter FULL.
REQ-025 FULL: swap SHALL toggle active_bank and return to IDLE; start in FULL or LOAD is ignored; swap in IDLE or LOAD is ignored.
REQ-026 weight_out SHALL be combinational from the active bank; new contents visible the cycle after the accepted swap; loads never disturb weight_out.
REQ-027 PW mapping: PE(r,c) = byte (c mod (BUS_W/DATA_W)) of word [r][c/(BUS_W/DATA_W)], byte 0 = LSBs.
REQ-028 DW mapping: for g < G, k,j < KSIZE, PE(KSIZE*g+k, KSIZE*g+j) = byte (KSIZE-1-k) of word [KSIZE*g+j][0]; all other PEs, incl. rows >= KSIZE*G, SHALL be 0.
REQ-029 DW mapping SHALL use the DW_PW_sel latched for the active bank (stored per bank at swap).

Reset
REQ-030 reset SHALL, in any state including mid-LOAD, set FSM IDLE, both banks and per-bank mode to 0, active_bank=0, counters=0, ready_w=0, load_done=0, shadow_full=0, weight_out=0.
REQ-031 reset SHALL take priority over start, swap and handshake in the same cycle.

Verification
REQ-032 PW: start, row_en=2, col_words=8, 16 words 0x03020100+i*0x04040404, swap -> PE(0,0)=0x00, PE(0,31)=0x1F, PE(1,0)=0x20; load_done one pulse.
REQ-033 DW: start, row_en=3, words 0x00A1B2C3, 0x00D4E5F6, 0x00112233, swap -> PE(0,0)=0xA1, PE(0,1)=0xD4, PE(2,2)=0x33, PE(3,*)=0, PE(0,3)=0.
REQ-034 Stall: valid_w toggled every other cycle during PW row_en=1, col_words=4 -> exactly 4 writes, load_done 1 cycle after 4th handshake.
REQ-035 Ping-pong: load bank1 while bank0 active -> weight_out unchanged until swap; swap in IDLE ignored; second start in FULL ignored.
REQ-036 reset asserted after 5 of 16 PW words -> all outputs 0, state IDLE; subsequent full load behaves as REQ-032.
REQ-037 Edge: row_en=40 clamps to 32; row_en=0 start ignored (ready_w stays 0).
